// File: rtl/tomasulo_pkg.sv
// Shared widths, result-source indices and the common-data-bus message type.
// Every unit that drives or snoops the CDB imports this package.
package tomasulo_pkg;

  localparam int TAG_W       = 4;
  localparam int DATA_W      = 32;
  localparam int NUM_CDB_SRC = 7;

  localparam int SRC_ADD1 = 0;
  localparam int SRC_ADD2 = 1;
  localparam int SRC_ADD3 = 2;
  localparam int SRC_MUL1 = 3;
  localparam int SRC_MUL2 = 4;
  localparam int SRC_LD1  = 5;
  localparam int SRC_LD2  = 6;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Zero latency; no backpressure of its own, the caller decides what a grant consumes.
module rr_arbiter #(
  parameter int N     = 7,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_grant
);

  logic [2*N-1:0] dbl;
  logic           found;
  int             idx;

  // Lower copy is masked below ptr, so the first hit in the doubled vector
  // is the round-robin winner; the upper copy supplies the wrap-around.
  always_comb begin
    dbl = {req, req};
    for (int k = 0; k < N; k++) begin
      if (k < int'(ptr)) dbl[k] = 1'b0;
    end
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < 2*N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

  always_comb begin
    any_grant = |req;
    winner    = IDX_W'((idx >= N) ? idx - N : idx);
    grant     = '0;
    if (any_grant) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per result source, round-robin grant, registered broadcast.
// Result visible one edge after capture; a source whose slot is full sees req_ready low and stalls.
module cdb_arbiter #(
  parameter int NUM_SRC = tomasulo_pkg::NUM_CDB_SRC,
  parameter int TAG_W   = tomasulo_pkg::TAG_W,
  parameter int DATA_W  = tomasulo_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        req_valid,
  output logic [NUM_SRC-1:0]        req_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  req_tag,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_SRC-1:0]        pending,
  output logic                      tag0_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } msg_t;

  logic [NUM_SRC-1:0] slot_vld_q, slot_vld_d;
  logic [TAG_W-1:0]   slot_tag_q  [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag_d  [NUM_SRC];
  logic [DATA_W-1:0]  slot_data_q [NUM_SRC];
  logic [DATA_W-1:0]  slot_data_d [NUM_SRC];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  msg_t               msg_q, msg_d;
  logic               tag0_err_q, tag0_err_d;

  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic               any_grant;
  logic [NUM_SRC-1:0] xfer;

  rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (slot_vld_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Ready depends only on registered state: a slot frees up in its own grant cycle.
  assign req_ready = ~slot_vld_q | grant;
  assign xfer      = req_valid & req_ready;

  always_comb begin
    slot_vld_d  = slot_vld_q & ~grant;
    slot_tag_d  = slot_tag_q;
    slot_data_d = slot_data_q;
    tag0_err_d  = tag0_err_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer[i]) begin
        if (req_tag[i*TAG_W +: TAG_W] == '0) begin
          tag0_err_d = 1'b1;
        end else begin
          slot_vld_d[i]  = 1'b1;
          slot_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
          slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    msg_d    = msg_q;
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      msg_d.valid = 1'b1;
      msg_d.tag   = slot_tag_q[winner];
      msg_d.data  = slot_data_q[winner];
      rr_ptr_d    = (winner == IDX_W'(NUM_SRC-1)) ? '0 : winner + IDX_W'(1);
    end else begin
      msg_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_vld_q <= '0;
      rr_ptr_q   <= '0;
      msg_q      <= '0;
      tag0_err_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_tag_q[i]  <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_tag_q  <= slot_tag_d;
      slot_data_q <= slot_data_d;
      rr_ptr_q    <= rr_ptr_d;
      msg_q       <= msg_d;
      tag0_err_q  <= tag0_err_d;
    end
  end

  assign cdb_valid = msg_q.valid;
  assign cdb_tag   = msg_q.tag;
  assign cdb_data  = msg_q.data;
  assign pending   = slot_vld_q;
  assign tag0_err  = tag0_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: slot-level reference model compared every cycle, plus directed scenarios.
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int N  = NUM_CDB_SRC;
  localparam int TW = TAG_W;
  localparam int DW = DATA_W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [N-1:0]    pending;
  logic            tag0_err;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .pending   (pending),
    .tag0_err  (tag0_err)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int lg_tag[$];
  int lg_cyc[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: the set of held results and the round-robin start point.
  bit            m_v    [N];
  logic [TW-1:0] m_tag  [N];
  logic [DW-1:0] m_data [N];
  int            m_ptr  = 0;
  bit            mc_v   = 1'b0;
  logic [TW-1:0] mc_tag = '0;
  logic [DW-1:0] mc_dat = '0;
  bit            m_err  = 1'b0;

  function automatic int m_pick();
    for (int k = 0; k < N; k++) begin
      if (m_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int w;
    w = m_pick();
    for (int i = 0; i < N; i++) r[i] = !m_v[i] || (i == w);
    return r;
  endfunction

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_v[i];
    return p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_ptr = 0; mc_v = 1'b0; mc_tag = '0; mc_dat = '0; m_err = 1'b0;
    end else begin
      int w;
      logic [N-1:0] rdy;
      logic [TW-1:0] t;
      rdy = m_ready();
      w   = m_pick();
      if (w >= 0) begin
        mc_v = 1'b1; mc_tag = m_tag[w]; mc_dat = m_data[w];
        m_v[w] = 1'b0;
        m_ptr = (w + 1) % N;
      end else begin
        mc_v = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && rdy[i]) begin
          t = req_tag[i*TW +: TW];
          if (t == '0) m_err = 1'b1;
          else begin
            m_v[i] = 1'b1; m_tag[i] = t; m_data[i] = req_data[i*DW +: DW];
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of every broadcast.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    check("cdb_valid", {63'd0, cdb_valid}, {63'd0, mc_v});
    check("cdb_tag", 64'(cdb_tag), 64'(mc_tag));
    check("cdb_data", 64'(cdb_data), 64'(mc_dat));
    check("pending", 64'(pending), 64'(m_pending()));
    check("req_ready", 64'(req_ready), 64'(m_ready()));
    check("tag0_err", {63'd0, tag0_err}, {63'd0, m_err});
    if (reset && cdb_valid) begin
      lg_tag.push_back(int'(cdb_tag));
      lg_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_tag[i*TW +: TW] = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [DW-1:0] dv(input int t);
    return DW'(32'hD000_0000 + t * 32'h101);
  endfunction

  int base, n, x4, pos9, lat;
  bit f0, f2, f4;
  int exp_ctd[7];
  int exp_bp[4];

  initial begin
    // Reset values while held
    step();
    step();
    check("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_cdb_data", 64'(cdb_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_tag0_err", {63'd0, tag0_err}, 64'd0);
    reset = 1'b1;
    step();
    check("rst_ready", 64'(req_ready), 64'h7f);

    // Single source
    put(SRC_ADD2, 4'd5, 32'h0000_00AA);
    check("single_ready", {63'd0, req_ready[SRC_ADD2]}, 64'd1);
    step();
    req_valid = '0;
    check("single_pend", 64'(pending), 64'h02);
    check("single_idle", {63'd0, cdb_valid}, 64'd0);
    step();
    check("single_valid", {63'd0, cdb_valid}, 64'd1);
    check("single_tag", 64'(cdb_tag), 64'd5);
    check("single_data", 64'(cdb_data), 64'hAA);
    check("single_pend_clr", 64'(pending), 64'd0);
    step();
    check("single_done", {63'd0, cdb_valid}, 64'd0);

    // All seven contend on one edge
    do_reset();
    step();
    base = lg_tag.size();
    for (int i = 0; i < N; i++) put(i, TW'(i + 1), dv(i + 1));
    step();
    req_valid = '0;
    check("ctd_ready_low", 64'(req_ready), 64'h01);
    repeat (8) step();
    exp_ctd = '{1, 2, 3, 4, 5, 6, 7};
    check("ctd_count", 64'(lg_tag.size() - base), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (base + i < lg_tag.size()) begin
        check("ctd_order", 64'(lg_tag[base + i]), 64'(exp_ctd[i]));
        check("ctd_b2b", 64'(lg_cyc[base + i] - lg_cyc[base]), 64'(i));
      end
    end

    // Fairness: src0 streams tags 1..8 while src4 injects tag 9 once
    do_reset();
    step();
    base = lg_tag.size();
    n = 1; x4 = -1;
    put(SRC_ADD1, 4'd1, dv(1));
    put(SRC_MUL2, 4'd9, dv(9));
    for (int c = 0; c < 20; c++) begin
      f0 = req_valid[0] && req_ready[0];
      f4 = req_valid[4] && req_ready[4];
      if (f4) x4 = cyc + 1;
      step();
      if (f0) begin
        n++;
        if (n > 8) req_valid[0] = 1'b0;
        else put(SRC_ADD1, TW'(n), dv(n));
      end
      if (f4) req_valid[4] = 1'b0;
    end
    step();
    pos9 = -1;
    n = 1;
    for (int i = base; i < lg_tag.size(); i++) begin
      if (lg_tag[i] == 9) pos9 = i;
      else begin
        check("fair_src0_seq", 64'(lg_tag[i]), 64'(n));
        n++;
      end
    end
    check("fair_src0_cnt", 64'(n - 1), 64'd8);
    check("fair_tag9_seen", {63'd0, (pos9 >= 0)}, 64'd1);
    lat = (pos9 >= 0) ? lg_cyc[pos9] - x4 : -1;
    check("fair_tag9_bound", {63'd0, (x4 > 0 && lat >= 1 && lat <= N)}, 64'd1);

    // Backpressure on src2 behind src0/src1
    do_reset();
    step();
    base = lg_tag.size();
    put(SRC_ADD1, 4'd1, dv(1));
    put(SRC_ADD2, 4'd2, dv(2));
    put(SRC_ADD3, 4'd3, dv(3));
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    put(SRC_ADD3, 4'd4, dv(4));
    check("bp_ready_low", {63'd0, req_ready[2]}, 64'd0);
    for (int c = 0; c < 8; c++) begin
      f2 = req_valid[2] && req_ready[2];
      step();
      if (f2) req_valid[2] = 1'b0;
    end
    exp_bp = '{1, 2, 3, 4};
    check("bp_count", 64'(lg_tag.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < lg_tag.size()) check("bp_order", 64'(lg_tag[base + i]), 64'(exp_bp[i]));
    end

    // Tag 0 is swallowed and flagged
    do_reset();
    step();
    base = lg_tag.size();
    put(SRC_LD2, 4'd0, 32'h1234_5678);
    step();
    req_valid = '0;
    check("t0_err", {63'd0, tag0_err}, 64'd1);
    check("t0_pend", 64'(pending), 64'd0);
    repeat (3) step();
    check("t0_sticky", {63'd0, tag0_err}, 64'd1);
    check("t0_no_bcast", 64'(lg_tag.size() - base), 64'd0);

    // Reset mid-operation with four results held
    do_reset();
    step();
    for (int i = 2; i < N; i++) put(i, TW'(i - 1), dv(i - 1));
    step();
    req_valid = '0;
    step();
    check("mid_pend4", 64'(pending), 64'h78);
    check("mid_valid", {63'd0, cdb_valid}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, cdb_valid}, 64'd0);
    check("mid_rst_pend", 64'(pending), 64'd0);
    step();
    reset = 1'b1;
    step();
    put(SRC_LD2, 4'd7, dv(7));
    put(SRC_ADD1, 4'd8, dv(8));
    step();
    req_valid = '0;
    step();
    check("post_first", 64'(cdb_tag), 64'd8);
    step();
    check("post_second", 64'(cdb_tag), 64'd7);
    repeat (2) step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
